flash_responder: RTL and testbench

SPI flash target for the serial flash read path: responds to the single-lane READ (0x03) command that our flash PHY issues, streaming bytes from an internal byte memory in increasing address order. It oversamples the SPI pins in its own clock domain, so it can sit on an FPGA as a flash emulator or in a testbench opposite the PHY. A side-band load port fills the memory before or between transactions.

---
 rtl/flash_pkg.sv | 24 ++
 rtl/flash_sync.sv | 40 ++++
 rtl/flash_responder.sv | 217 +++++++++++++++++++++
 tb/tb_flash_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// flash_pkg: shared constants and types for the SPI flash responder.
//   FLASH_CMD_READ  : the only opcode serviced (single-lane READ)
//   CMD_BITS/ADDR_BITS and their last-bit indices for the bit counter
//   flash_state_e   : responder state encoding
package flash_pkg;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 24;

  localparam logic [4:0] CMD_LAST  = 5'(CMD_BITS - 1);
  localparam logic [4:0] ADDR_LAST = 5'(ADDR_BITS - 1);
  localparam logic [4:0] BYTE_LAST = 5'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } flash_state_e;

endpackage

// File: rtl/flash_sync.sv
// flash_sync: two-flop synchroniser for an asynchronous pin followed by an
// edge-detect register.
//   clk_i, rst_ni : local clock, asynchronous active-low reset
//   d_i           : asynchronous input pin
//   q_o           : synchronised level
//   rise_o/fall_o : one-cycle pulses on synchronised rising/falling edges
// RESET_VAL is the idle level of the pin, so no edge is reported out of reset
// while the pin sits at that level.
module flash_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/flash_responder.sv
// flash_responder: SPI mode-0 flash target answering READ (0x03) from an
// internal byte memory, oversampling the SPI pins in its own clock domain.
//   flash_clock_i, flash_reset_ni : clock, asynchronous active-low reset
//   flash_cs_n, flash_sck, flash_mosi : SPI pins from the initiator (async)
//   flash_miso  : read data, MSB first, updated after SCK falling edges
//   load_we_i, load_addr_i, load_data_i : side-band memory write port
//   busy_o      : synchronised chip select is asserted
//   cmd_err_o   : one-cycle pulse on an unsupported opcode
module flash_responder
  import flash_pkg::*;
#(
  parameter  int MEM_BYTES = 4096,
  localparam int AW        = $clog2(MEM_BYTES)
) (
  input  logic          flash_clock_i,
  input  logic          flash_reset_ni,
  input  logic          flash_cs_n,
  input  logic          flash_sck,
  input  logic          flash_mosi,
  output logic          flash_miso,
  input  logic          load_we_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [7:0]    load_data_i,
  output logic          busy_o,
  output logic          cmd_err_o
);

  localparam logic [1:0] SETTLE_DONE = 2'd2;

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_lvl, sck_rise, sck_fall;

  flash_sync #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk_i  (flash_clock_i),
    .rst_ni (flash_reset_ni),
    .d_i    (flash_cs_n),
    .q_o    (cs_lvl),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  flash_sync #(.RESET_VAL(1'b0)) u_sck_sync (
    .clk_i  (flash_clock_i),
    .rst_ni (flash_reset_ni),
    .d_i    (flash_sck),
    .q_o    (sck_lvl),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  // MOSI delayed to line up with the synchronised SCK level
  logic mosi_meta_q, mosi_sync_q;

  always_ff @(posedge flash_clock_i) begin
    mosi_meta_q <= flash_mosi;
    mosi_sync_q <= mosi_meta_q;
  end

  flash_state_e state_q, state_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic          miso_q, miso_d;
  logic          cmd_err_q, cmd_err_d;
  logic          armed_q, armed_d;
  logic [1:0]    settle_q, settle_d;
  logic [22:0]   shift_q, shift_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    prefetch_q;
  logic [23:0]   shift_in;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic [7:0] mem_q [MEM_BYTES];

  // The bit being shifted in completes the 8-bit opcode or 24-bit address
  assign shift_in = {shift_q, mosi_sync_q};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    miso_d    = miso_q;
    cmd_err_d = 1'b0;
    armed_d   = armed_q;
    settle_d  = settle_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    tx_d      = tx_q;
    rd_en     = 1'b0;
    rd_addr   = ptr_q;

    // The synchronisers hold fake idle values for two cycles after reset.
    // Only once real pin values have arrived and CS is seen high may a CS
    // falling edge start a transaction; a CS held low across reset release
    // therefore never looks like a fresh select.
    if (settle_q != SETTLE_DONE) begin
      settle_d = settle_q + 2'd1;
    end
    if ((settle_q == SETTLE_DONE) && cs_lvl) begin
      armed_d = 1'b1;
    end

    if (cs_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall && armed_q && !sck_lvl) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
          end
        end

        ST_CMD: begin
          if (sck_rise) begin
            shift_d   = 23'(shift_in);
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == CMD_LAST) begin
              bit_cnt_d = '0;
              if (8'(shift_in) == FLASH_CMD_READ) begin
                state_d = ST_ADDR;
              end else begin
                state_d   = ST_IGNORE;
                cmd_err_d = 1'b1;
              end
            end
          end
        end

        ST_ADDR: begin
          if (sck_rise) begin
            shift_d   = 23'(shift_in);
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == ADDR_LAST) begin
              ptr_d     = AW'(shift_in);
              rd_en     = 1'b1;
              rd_addr   = AW'(shift_in);
              bit_cnt_d = '0;
              state_d   = ST_DATA;
            end
          end
        end

        ST_DATA: begin
          // bit_cnt_q counts rising edges within the current byte, so zero
          // at a falling edge marks the first bit of a new byte.
          if (sck_fall) begin
            if (bit_cnt_q == 5'd0) begin
              tx_d = prefetch_q;
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
            miso_d = tx_d[7];
          end
          if (sck_rise) begin
            if (bit_cnt_q == BYTE_LAST) begin
              bit_cnt_d = '0;
              ptr_d     = ptr_q + AW'(1);
              rd_en     = 1'b1;
              rd_addr   = ptr_q + AW'(1);
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end

        ST_IGNORE: begin
          miso_d = 1'b0;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge flash_clock_i or negedge flash_reset_ni) begin
    if (!flash_reset_ni) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      miso_q    <= 1'b0;
      cmd_err_q <= 1'b0;
      armed_q   <= 1'b0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      miso_q    <= miso_d;
      cmd_err_q <= cmd_err_d;
      armed_q   <= armed_d;
      settle_q  <= settle_d;
    end
  end

  always_ff @(posedge flash_clock_i) begin
    shift_q <= shift_d;
    ptr_q   <= ptr_d;
    tx_q    <= tx_d;
  end

  // Single-clock memory; a same-cycle read of a written address sees old data
  always_ff @(posedge flash_clock_i) begin
    if (load_we_i) begin
      mem_q[load_addr_i] <= load_data_i;
    end
    if (rd_en) begin
      prefetch_q <= mem_q[rd_addr];
    end
  end

  assign flash_miso = miso_q;
  assign busy_o     = ~cs_lvl;
  assign cmd_err_o  = cmd_err_q;

endmodule

// File: tb/tb_flash_responder.sv
module tb_flash_responder;

  localparam int MEM_BYTES = 4096;
  localparam int AW        = 12;
  localparam int HP        = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs_n = 1'b1;
  logic          sck = 1'b0;
  logic          mosi = 1'b0;
  logic          miso;
  logic          we = 1'b0;
  logic [AW-1:0] laddr = '0;
  logic [7:0]    ldata = '0;
  logic          busy;
  logic          cmd_err;

  flash_responder #(.MEM_BYTES(MEM_BYTES)) dut (
    .flash_clock_i  (clk),
    .flash_reset_ni (rst_n),
    .flash_cs_n     (cs_n),
    .flash_sck      (sck),
    .flash_mosi     (mosi),
    .flash_miso     (miso),
    .load_we_i      (we),
    .load_addr_i    (laddr),
    .load_data_i    (ldata),
    .busy_o         (busy),
    .cmd_err_o      (cmd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int rise8_cyc = 0;

  logic [7:0] shadow [MEM_BYTES];
  logic [7:0] exp_q [$];

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t tbl [5];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd_err === 1'b1) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    we = 1'b1; laddr = a; ldata = d;
    @(negedge clk);
    we = 1'b0;
    shadow[a] = d;
  endtask

  // Drives CS low and clocks opcode+address plus ndata data bits; every
  // completed received byte is compared against the scoreboard head.
  task automatic spi_txn(input logic [7:0] op, input logic [23:0] addr, input int ndata,
                         input string tag);
    logic [31:0] hdr;
    logic [7:0]  rx;
    logic [7:0]  e;
    bit          hdr_zero;
    bit          busy_ok;
    hdr = {op, addr};
    rx = '0;
    hdr_zero = 1'b1;
    busy_ok = 1'b1;
    cs_n = 1'b0;
    wait_clk(HP + 1);
    for (int i = 0; i < 32 + ndata; i++) begin
      mosi = (i < 32) ? hdr[31 - i] : 1'b0;
      wait_clk(HP);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (i < 32) begin
        if (miso !== 1'b0) hdr_zero = 1'b0;
      end else begin
        rx = {rx[6:0], miso};
        if (((i - 32) % 8) == 7) begin
          if (exp_q.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'(rx), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check({tag, "_byte"}, 32'(rx), 32'(e));
          end
        end
      end
      sck = 1'b1;
      if (i == 7) rise8_cyc = cyc;
      wait_clk(HP);
      sck = 1'b0;
    end
    check({tag, "_hdr_miso_zero"}, 32'(hdr_zero), 32'd1);
    check({tag, "_busy_high"}, 32'(busy_ok), 32'd1);
  endtask

  task automatic cs_end();
    wait_clk(HP);
    cs_n = 1'b1;
    wait_clk(HP + 4);
  endtask

  initial begin
    logic [23:0] up;
    logic [23:0] a24;
    int          a;
    int          n;
    bit          ign_zero;
    logic [31:0] hdr;

    tbl[0] = '{24'h000101, 8'hAD, 8'hBE};
    tbl[1] = '{24'h000102, 8'hBE, 8'hEF};
    tbl[2] = '{24'hFFFFFF, 8'h5A, 8'hC3};
    tbl[3] = '{24'hABCFFF, 8'h5A, 8'hC3};
    tbl[4] = '{24'h000050, 8'h11, 8'h22};

    // Reset state
    wait_clk(3);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_err", 32'(cmd_err), 32'd0);
    rst_n = 1'b1;
    wait_clk(6);

    load(12'h100, 8'hDE); load(12'h101, 8'hAD);
    load(12'h102, 8'hBE); load(12'h103, 8'hEF);
    load(12'hFFF, 8'h5A); load(12'h000, 8'hC3);
    load(12'h050, 8'h11); load(12'h051, 8'h22);
    load(12'h010, 8'hFF); load(12'h011, 8'hFF);
    load(12'h020, 8'h81); load(12'h021, 8'h7E);
    check("idle_busy", 32'(busy), 32'd0);

    // Four-byte stream
    exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    spi_txn(8'h03, 24'h000100, 32, "read4");
    cs_end();
    check("read4_sb_empty", 32'(exp_q.size()), 32'd0);
    check("after_cs_busy", 32'(busy), 32'd0);

    // Table of two-byte reads incl. wrap and ignored upper address bits
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(tbl[k].b0);
      exp_q.push_back(tbl[k].b1);
      spi_txn(8'h03, tbl[k].addr, 16, $sformatf("tbl%0d", k));
      cs_end();
    end
    check("no_err_pulses", 32'(err_cnt), 32'd0);

    // Unsupported opcode
    err_cnt = 0;
    spi_txn(8'h9F, 24'h000100, 0, "badop");
    cs_end();
    check("badop_err_count", 32'(err_cnt), 32'd1);
    check("badop_err_timing", 32'(err_cyc - rise8_cyc), 32'd3);

    // Partial byte then CS rise
    spi_txn(8'h03, 24'h000010, 4, "partial");
    wait_clk(HP);
    check("partial_miso_hi", 32'(miso), 32'd1);
    cs_n = 1'b1;
    wait_clk(3);
    check("partial_cs_miso0", 32'(miso), 32'd0);
    wait_clk(HP + 4);
    exp_q.push_back(8'h81); exp_q.push_back(8'h7E);
    spi_txn(8'h03, 24'h000020, 16, "after_partial");
    cs_end();

    // Reset mid-DATA with CS held low across release
    spi_txn(8'h03, 24'h000010, 4, "pre_rst");
    wait_clk(HP);
    check("pre_rst_miso_hi", 32'(miso), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_miso", 32'(miso), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    wait_clk(2);
    rst_n = 1'b1;
    ign_zero = 1'b1;
    hdr = 32'h03000010;
    for (int i = 0; i < 40; i++) begin
      mosi = (i < 32) ? hdr[31 - i] : 1'b0;
      wait_clk(HP);
      if (miso !== 1'b0) ign_zero = 1'b0;
      sck = 1'b1;
      wait_clk(HP);
      sck = 1'b0;
    end
    wait_clk(HP);
    if (miso !== 1'b0) ign_zero = 1'b0;
    check("post_rst_ignored", 32'(ign_zero), 32'd1);
    cs_end();
    exp_q.push_back(8'h81); exp_q.push_back(8'h7E);
    spi_txn(8'h03, 24'h000020, 16, "post_rst_read");
    cs_end();

    // Random back-to-back reads of 1/2/4 bytes
    for (int k = 0; k < 256; k++) load(AW'(12'h200 + k), 8'($urandom_range(0, 255)));
    for (int t = 0; t < 12; t++) begin
      a = $urandom_range(12'h200, 12'h2FC);
      n = 1 << $urandom_range(0, 2);
      up = 24'($urandom_range(0, 4095));
      a24 = {up[11:0], 12'(a)};
      for (int k = 0; k < n; k++) exp_q.push_back(shadow[(a + k) % MEM_BYTES]);
      spi_txn(8'h03, a24, 8 * n, $sformatf("rnd%0d", t));
      cs_end();
    end
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    check("final_err_count", 32'(err_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
